// File: rtl/btn_press_decoder_if.sv
// btn_press_decoder_if: button pin in, conditioned button events out.
// The master side drives the raw pin; the slave side is the decoder.
interface btn_press_decoder_if;
  logic BTN_RAW;    // raw button pin, asynchronous, 1 = pressed
  logic BTN_LEVEL;  // debounced button level
  logic BTN_PULSE;  // one-cycle pulse per short press
  logic CLR;        // one-cycle pulse per long press

  modport master (output BTN_RAW, input BTN_LEVEL, BTN_PULSE, CLR);
  modport slave  (input BTN_RAW, output BTN_LEVEL, BTN_PULSE, CLR);
endinterface

// File: rtl/btn_press_decoder.sv
// btn_press_decoder: conditions one raw push-button into the stopwatch's
// event pulses. Chain is: 2-FF synchronizer -> stability-counter debouncer
// -> press-classification FSM.
// Optional feature macro BTN_LONG_PRESS_EN:
//   defined     - short press pulses BTN_PULSE on release, a hold of
//                 LONG_CYCLES pulses CLR instead.
//   not defined - BTN_PULSE fires on the press edge, CLR is tied low and
//                 LONG_MS has no effect on behaviour.
module btn_press_decoder #(
  parameter int unsigned CLK_FREQ    = 125_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic               CLK,
  input  logic               RST,   // asynchronous, active-low
  btn_press_decoder_if.slave bus
);

  localparam int unsigned DB_CYCLES   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LONG_CYCLES = CLK_FREQ / 1000 * LONG_MS;
  localparam logic [31:0] DB_LAST     = 32'(DB_CYCLES - 1);

  // A zero-length window would make the compare values wrap to all-ones.
  if (DB_CYCLES == 0 || LONG_CYCLES == 0) begin : g_bad_cfg
    $error("btn_press_decoder: debounce and long-press windows must be >= 1 cycle");
  end

  // ---------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------
  logic [1:0] sync_q, sync_d;
  logic       s;

  // Shift the raw pin through two flops before anything looks at it.
  always_comb sync_d = {sync_q[0], bus.BTN_RAW};

  assign s = sync_q[1];

  // ---------------------------------------------------------------------
  // Debouncer
  // ---------------------------------------------------------------------
  logic        level_q, level_d;
  logic [31:0] db_cnt_q, db_cnt_d;

  // Accept a new level only after it has differed from the current one for
  // DB_CYCLES consecutive cycles; any return to the current level restarts.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (s != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = s;
      end else begin
        db_cnt_d = db_cnt_q + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Press classification
  // ---------------------------------------------------------------------
`ifdef BTN_LONG_PRESS_EN
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRESS = 2'b01,
    LONG  = 2'b10
  } state_e;

  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);

  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        clr_q, clr_d;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRESS = 2'b01
  } state_e;
`endif

  state_e state_q, state_d;
  logic   pulse_q, pulse_d;

  // Next state and registered event pulses. In IDLE a high level can only
  // mean a fresh rising edge, since every path back to IDLE needs level 0.
  // Release is tested before the hold limit so it wins a same-cycle tie.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
`ifdef BTN_LONG_PRESS_EN
    hold_cnt_d = hold_cnt_q;
    clr_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (level_q) begin
          state_d = PRESS;
`ifdef BTN_LONG_PRESS_EN
          hold_cnt_d = '0;
`else
          pulse_d = 1'b1;
`endif
        end
      end
      PRESS: begin
`ifdef BTN_LONG_PRESS_EN
        hold_cnt_d = hold_cnt_q + 32'd1;
        if (!level_q) begin
          state_d = IDLE;
          pulse_d = 1'b1;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d = LONG;
          clr_d   = 1'b1;
        end
`else
        if (!level_q) begin
          state_d = IDLE;
        end
`endif
      end
`ifdef BTN_LONG_PRESS_EN
      LONG: begin
        if (!level_q) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // All state clears asynchronously so outputs drop the moment RST falls.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= IDLE;
      pulse_q  <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
      hold_cnt_q <= '0;
      clr_q      <= 1'b0;
`endif
    end else begin
      sync_q   <= sync_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      pulse_q  <= pulse_d;
`ifdef BTN_LONG_PRESS_EN
      hold_cnt_q <= hold_cnt_d;
      clr_q      <= clr_d;
`endif
    end
  end

  assign bus.BTN_LEVEL = level_q;
  assign bus.BTN_PULSE = pulse_q;
`ifdef BTN_LONG_PRESS_EN
  assign bus.CLR = clr_q;
`else
  assign bus.CLR = 1'b0;
`endif

endmodule
